// File: rtl/rf_seq_pkg.sv
// Shared types and constants for the register-file access sequencer.
// ST_CLEAR exists only when RF_SEQ_CLEAR_EN is defined.
package rf_seq_pkg;

  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned ADDR_W_DEF   = 3;
  localparam int unsigned NUM_REGS     = 8;
  localparam int unsigned EXEC_LAT_MAX = 8;

  // One counter serves both EXEC timing and CLEAR address stepping.
  localparam int unsigned CNT_W =
    $clog2((EXEC_LAT_MAX > NUM_REGS) ? EXEC_LAT_MAX : NUM_REGS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WRITE
`ifdef RF_SEQ_CLEAR_EN
    , ST_CLEAR
`endif
  } rf_seq_state_e;

endpackage

// File: rtl/rf_access_sequencer_if.sv
// Command handshake between the issue logic (master) and the sequencer (slave).
interface rf_access_sequencer_if #(
  parameter int unsigned ADDR_W = rf_seq_pkg::ADDR_W_DEF
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_dst;
  logic [ADDR_W-1:0] cmd_src_a;
  logic [ADDR_W-1:0] cmd_src_b;
  logic              cmd_wb;

  modport master (
    output cmd_valid, cmd_dst, cmd_src_a, cmd_src_b, cmd_wb,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dst, cmd_src_a, cmd_src_b, cmd_wb,
    output cmd_ready
  );
endinterface

// File: rtl/rf_seq_cnt.sv
// Loadable down-counter with zero flag; load wins over decrement, saturates at zero.
module rf_seq_cnt #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] value_o,
  output logic             is_zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o   = cnt_q;
  assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/rf_access_sequencer.sv
// Register-file access sequencer: READ -> EXEC (EXEC_LAT cycles) -> optional WRITE.
// Define RF_SEQ_CLEAR_EN to add clr_req/clr_done and the register-clear sequence.
module rf_access_sequencer
  import rf_seq_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned EXEC_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  rf_access_sequencer_if.slave  cmd,
  input  logic [DATA_W-1:0]     alu_result,
  output logic [ADDR_W-1:0]     R_Adr,
  output logic [ADDR_W-1:0]     S_Adr,
  output logic                  alu_start,
  output logic [ADDR_W-1:0]     W_Adr,
  output logic [DATA_W-1:0]     W,
  output logic                  we,
  output logic                  busy,
  output logic                  done
`ifdef RF_SEQ_CLEAR_EN
  ,
  input  logic                  clr_req,
  output logic                  clr_done
`endif
);

  if ((EXEC_LAT < 1) || (EXEC_LAT > EXEC_LAT_MAX)) begin : g_bad_exec_lat
    $error("EXEC_LAT must be in 1..%0d", EXEC_LAT_MAX);
  end

  rf_seq_state_e     state_q, state_d;
  logic [ADDR_W-1:0] r_adr_q, r_adr_d;
  logic [ADDR_W-1:0] s_adr_q, s_adr_d;
  logic [ADDR_W-1:0] w_adr_q, w_adr_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] w_q, w_d;
  logic              wb_q, wb_d;
  logic              ready_c;
  logic              clr_start;

  logic              cnt_load;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt_load_val;
  logic [CNT_W-1:0]  cnt_value;
  logic              cnt_zero;

`ifdef RF_SEQ_CLEAR_EN
  logic clr_done_q, clr_done_d;
  assign clr_start = clr_req;
  assign clr_done  = clr_done_q;
`else
  logic unused_cnt_value;
  assign clr_start        = 1'b0;
  assign unused_cnt_value = ^cnt_value;
`endif

  rf_seq_cnt #(
    .WIDTH (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .value_o    (cnt_value),
    .is_zero_o  (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    r_adr_d      = r_adr_q;
    s_adr_d      = s_adr_q;
    w_adr_d      = w_adr_q;
    dst_d        = dst_q;
    w_d          = w_q;
    wb_d         = wb_q;
    ready_c      = 1'b0;
    alu_start    = 1'b0;
    we           = 1'b0;
    done         = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;
`ifdef RF_SEQ_CLEAR_EN
    clr_done_d   = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // A pending clear pre-empts the command port for this cycle.
        if (clr_start) begin
`ifdef RF_SEQ_CLEAR_EN
          state_d      = ST_CLEAR;
          w_adr_d      = '0;
          w_d          = '0;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(NUM_REGS - 1);
`endif
        end else begin
          ready_c = 1'b1;
          if (cmd.cmd_valid) begin
            r_adr_d = cmd.cmd_src_a;
            s_adr_d = cmd.cmd_src_b;
            dst_d   = cmd.cmd_dst;
            wb_d    = cmd.cmd_wb;
            state_d = ST_READ;
          end
        end
      end

      ST_READ: begin
        alu_start    = 1'b1;
        cnt_load     = 1'b1;
        cnt_load_val = CNT_W'(EXEC_LAT - 1);
        state_d      = ST_EXEC;
      end

      ST_EXEC: begin
        if (cnt_zero) begin
          w_d = alu_result;
          if (wb_q) begin
            w_adr_d = dst_q;
            state_d = ST_WRITE;
          end else begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_WRITE: begin
        we      = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end

`ifdef RF_SEQ_CLEAR_EN
      ST_CLEAR: begin
        we = 1'b1;
        // Address = NUM_REGS-1 - counter, so the next address is NUM_REGS - counter.
        if (cnt_zero) begin
          clr_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
          w_adr_d = ADDR_W'(NUM_REGS - 32'(cnt_value));
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      r_adr_q    <= '0;
      s_adr_q    <= '0;
      w_adr_q    <= '0;
      dst_q      <= '0;
      w_q        <= '0;
      wb_q       <= 1'b0;
`ifdef RF_SEQ_CLEAR_EN
      clr_done_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      r_adr_q    <= r_adr_d;
      s_adr_q    <= s_adr_d;
      w_adr_q    <= w_adr_d;
      dst_q      <= dst_d;
      w_q        <= w_d;
      wb_q       <= wb_d;
`ifdef RF_SEQ_CLEAR_EN
      clr_done_q <= clr_done_d;
`endif
    end
  end

  assign cmd.cmd_ready = ready_c & reset;
  assign busy          = (state_q != ST_IDLE);
  assign R_Adr         = r_adr_q;
  assign S_Adr         = s_adr_q;
  assign W_Adr         = w_adr_q;
  assign W             = w_q;

endmodule

// File: tb/tb_rf_access_sequencer.sv
// Randomized bench: the bench owns the register file and ALU, and predicts each
// command's cycle-by-cycle outputs from its position relative to the handshake.
module tb_rf_access_sequencer;

  localparam int unsigned L  = 2;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;

  logic          clk;
  logic          reset;
  logic [DW-1:0] alu_result;
  logic [AW-1:0] R_Adr, S_Adr, W_Adr;
  logic [DW-1:0] W;
  logic          alu_start, we, busy, done;
`ifdef RF_SEQ_CLEAR_EN
  logic          clr_req;
  logic          clr_done;
`endif

  rf_access_sequencer_if #(.ADDR_W(AW)) cmd_if ();

  rf_access_sequencer #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .EXEC_LAT (L)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd_if),
    .alu_result (alu_result),
    .R_Adr      (R_Adr),
    .S_Adr      (S_Adr),
    .alu_start  (alu_start),
    .W_Adr      (W_Adr),
    .W          (W),
    .we         (we),
    .busy       (busy),
    .done       (done)
`ifdef RF_SEQ_CLEAR_EN
    ,
    .clr_req    (clr_req),
    .clr_done   (clr_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] rf     [8];
  logic [DW-1:0] ref_rf [8];
  always @(posedge clk) if (we) rf[W_Adr] <= W;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [DW-1:0] last_w;
  int unsigned acc_cyc;
  int unsigned prev_period;
  bit op_inc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] alu_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return op_inc ? a + 16'd1 : a + b;
  endfunction

  // Starts at a negedge in an idle cycle; returns at the negedge of the next idle cycle.
  task automatic run_cmd(input logic [AW-1:0] dst, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic wb, input bit hold, input bit b2b);
    logic [DW-1:0] exp_w;
    int unsigned   last_k;
    check_eq("idle_ready", cmd_if.cmd_ready, 1);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_we", we, 0);
    check_eq("idle_W_hold", W, last_w);
    cmd_if.cmd_dst   = dst;
    cmd_if.cmd_src_a = a;
    cmd_if.cmd_src_b = b;
    cmd_if.cmd_wb    = wb;
    cmd_if.cmd_valid = 1'b1;
    exp_w  = alu_op(ref_rf[a], ref_rf[b]);
    last_k = wb ? L + 1 : L;
    @(posedge clk);
    for (int unsigned k = 0; k <= last_k; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (b2b) check_eq("accept_period", cyc - acc_cyc, prev_period);
        acc_cyc = cyc;
      end
      check_eq("busy", busy, 1);
      check_eq("ready_busy", cmd_if.cmd_ready, 0);
      check_eq("alu_start", alu_start, (k == 0));
      check_eq("R_Adr", R_Adr, a);
      check_eq("S_Adr", S_Adr, b);
      check_eq("we", we, (wb && k == L + 1));
      check_eq("done", done, (k == last_k));
      if (wb && k == L + 1) begin
        check_eq("W_Adr", W_Adr, dst);
        check_eq("W", W, exp_w);
      end
      // Only the last EXEC cycle carries a real ALU result; other cycles carry noise.
      alu_result = (k == L) ? alu_op(rf[R_Adr], rf[S_Adr]) : DW'($urandom);
      if (hold) begin
        {cmd_if.cmd_dst, cmd_if.cmd_src_a, cmd_if.cmd_src_b, cmd_if.cmd_wb} = 10'($urandom);
      end else begin
        cmd_if.cmd_valid = 1'b0;
      end
    end
    if (wb) ref_rf[dst] = exp_w;
    last_w      = exp_w;
    prev_period = last_k + 2;
    @(negedge clk);
  endtask

  task automatic reset_abort(input logic [AW-1:0] dst, input logic [AW-1:0] a, input logic [AW-1:0] b);
    cmd_if.cmd_dst   = dst;
    cmd_if.cmd_src_a = a;
    cmd_if.cmd_src_b = b;
    cmd_if.cmd_wb    = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_busy_before", busy, 1);
    alu_result = DW'($urandom);
    #2 reset = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_we", we, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_ready_in_reset", cmd_if.cmd_ready, 0);
    check_eq("abort_R_Adr", R_Adr, 0);
    check_eq("abort_W", W, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int unsigned i = 0; i < L + 2; i++) begin
      #1;
      check_eq("post_abort_ready", cmd_if.cmd_ready, 1);
      check_eq("post_abort_we", we, 0);
      check_eq("post_abort_done", done, 0);
      @(negedge clk);
    end
    check_eq("abort_no_write", rf[dst], ref_rf[dst]);
    last_w = '0;
  endtask

  initial begin
    logic [AW-1:0] d, a, b;
    logic          wb;
    bit            hold;
    int unsigned   gap;
    reset            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_dst   = '0;
    cmd_if.cmd_src_a = '0;
    cmd_if.cmd_src_b = '0;
    cmd_if.cmd_wb    = 1'b0;
    alu_result       = '0;
    op_inc           = 1'b0;
    last_w           = '0;
    acc_cyc          = 0;
    prev_period      = 0;
`ifdef RF_SEQ_CLEAR_EN
    clr_req          = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      rf[i]     = DW'($urandom);
      ref_rf[i] = rf[i];
    end
    rf[1] = 16'h00A0; ref_rf[1] = 16'h00A0;
    rf[2] = 16'h0005; ref_rf[2] = 16'h0005;

    repeat (2) @(negedge clk);
    check_eq("rst_ready", cmd_if.cmd_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_R_Adr", R_Adr, 0);
    check_eq("rst_S_Adr", S_Adr, 0);
    check_eq("rst_W_Adr", W_Adr, 0);
    check_eq("rst_W", W, 0);
    check_eq("rst_we", we, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_alu_start", alu_start, 0);
    reset = 1'b1;
    @(negedge clk);

    // 0x00A0 + 0x0005 = 0x00A5 written to r3, then the execute-only variant.
    run_cmd(3'd3, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0);
    check_eq("r3_written", rf[3], 16'h00A5);
    run_cmd(3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 1'b1);

    // cmd_valid held high with scrambled fields while busy.
    run_cmd(3'd6, 3'd0, 3'd7, 1'b1, 1'b1, 1'b1);
    run_cmd(3'd2, 3'd4, 3'd1, 1'b1, 1'b1, 1'b1);
    run_cmd(3'd7, 3'd6, 3'd3, 1'b1, 1'b1, 1'b1);
    run_cmd(3'd0, 3'd5, 3'd2, 1'b0, 1'b1, 1'b1);
    run_cmd(3'd1, 3'd2, 3'd6, 1'b1, 1'b0, 1'b1);

    reset_abort(3'd4, 3'd1, 3'd2);

    op_inc = 1'b1;
    rf[5] = 16'h1234; ref_rf[5] = 16'h1234;
    run_cmd(3'd5, 3'd5, 3'd0, 1'b1, 1'b0, 1'b0);
    check_eq("r5_inc", rf[5], 16'h1235);
    op_inc = 1'b0;

    for (int n = 0; n < 24; n++) begin
      {d, a, b, wb} = 10'($urandom);
      hold = 1'($urandom);
      gap  = $urandom_range(0, 2);
      for (int unsigned g = 0; g < gap; g++) begin
        cmd_if.cmd_valid = 1'b0;
        check_eq("gap_ready", cmd_if.cmd_ready, 1);
        check_eq("gap_busy", busy, 0);
        @(negedge clk);
      end
      run_cmd(d, a, b, wb, hold, (gap == 0));
    end
    cmd_if.cmd_valid = 1'b0;

`ifdef RF_SEQ_CLEAR_EN
    for (int i = 0; i < 8; i++) begin
      rf[i]     = 16'hFFFF;
      ref_rf[i] = 16'hFFFF;
    end
    cmd_if.cmd_dst   = 3'd4;
    cmd_if.cmd_src_a = 3'd1;
    cmd_if.cmd_src_b = 3'd2;
    cmd_if.cmd_wb    = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    clr_req          = 1'b1;
    #1;
    check_eq("clr_masks_ready", cmd_if.cmd_ready, 0);
    @(posedge clk);
    @(negedge clk);
    clr_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq("clr_we", we, 1);
      check_eq("clr_W_Adr", W_Adr, i);
      check_eq("clr_W", W, 0);
      check_eq("clr_busy", busy, 1);
      check_eq("clr_done_early", clr_done, 0);
      @(negedge clk);
    end
    check_eq("clr_done", clr_done, 1);
    check_eq("clr_busy_after", busy, 0);
    for (int i = 0; i < 8; i++) ref_rf[i] = '0;
    last_w = '0;
    run_cmd(3'd4, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0);
    check_eq("clr_done_once", clr_done, 0);
`endif

    for (int i = 0; i < 8; i++) check_eq($sformatf("rf_final[%0d]", i), rf[i], ref_rf[i]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
